// File: rtl/sd_pkg.sv
// Shared definitions for the SD sector arbiter: FSM encoding, sector geometry,
// SD command codes and a counter-width helper.
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_READY,
    ST_ISSUE,
    ST_TRANSFER,
    ST_RELEASE
  } arb_state_t;

  localparam int   SD_SECTOR_BYTES = 512;
  localparam int   SD_ADDR_W       = 26;
  localparam int   SD_BYTE_CNT_W   = 10;

  localparam logic SD_OP_READ      = 1'b0;
  localparam logic SD_OP_WRITE     = 1'b1;

  // Keeps the timeout counter at least one bit wide for tiny timeout values.
  function automatic int sd_cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sd_xfer_counter.sv
// Byte counter (saturating) and timeout counter for one sector transfer.
// Both are cleared together when a new command is issued.
module sd_xfer_counter
  import sd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_byte,
  input  logic                     i_tick,
  output logic [SD_BYTE_CNT_W-1:0] o_byte_count_next,
  output logic                     o_timeout
);

  localparam int TW = sd_cnt_width(TIMEOUT_CYCLES);
  localparam logic [SD_BYTE_CNT_W-1:0] BYTE_MAX = '1;

  logic [SD_BYTE_CNT_W-1:0] r_byte_count;
  logic [TW-1:0]            r_tmo_count;
  logic [SD_BYTE_CNT_W-1:0] w_byte_next;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_byte_next = r_byte_count;
    if (i_byte && (r_byte_count != BYTE_MAX)) begin
      w_byte_next = r_byte_count + 1'b1;
    end
  end

  assign o_byte_count_next = w_byte_next;
  assign o_timeout         = (r_tmo_count == TW'(TIMEOUT_CYCLES - 1));

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_count <= '0;
      r_tmo_count  <= '0;
    end else if (i_clear) begin
      r_byte_count <= '0;
      r_tmo_count  <= '0;
    end else begin
      r_byte_count <= w_byte_next;
      if (i_tick && !o_timeout) begin
        r_tmo_count <= r_tmo_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sd_sector_arbiter.sv
// Two-requester round-robin arbiter that owns an SD controller for one sector
// operation at a time, tracking byte count and a transfer timeout.
module sd_sector_arbiter
  import sd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int SECTOR_BYTES   = SD_SECTOR_BYTES
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 r0_req,
  input  logic                 r0_op,
  input  logic [SD_ADDR_W-1:0] r0_sector,
  input  logic [7:0]           r0_wdata,
  output logic                 r0_grant,
  output logic                 r0_byte,
  output logic                 r0_done,
  output logic                 r0_err,

  input  logic                 r1_req,
  input  logic                 r1_op,
  input  logic [SD_ADDR_W-1:0] r1_sector,
  input  logic [7:0]           r1_wdata,
  output logic                 r1_grant,
  output logic                 r1_byte,
  output logic                 r1_done,
  output logic                 r1_err,

  output logic [7:0]           rdata,

  output logic                 sd_op_code,
  output logic [SD_ADDR_W-1:0] sd_sector_address,
  output logic [7:0]           sd_outgoing_byte,
  output logic                 sd_execute,
  input  logic                 sd_busy,
  input  logic                 sd_finished_byte,
  input  logic                 sd_finished_sector,
  input  logic [7:0]           sd_incoming_byte
);

  arb_state_t               r_state;
  arb_state_t               w_next_state;
  logic                     r_owner;
  logic                     r_ptr;
  logic                     r_err;
  logic                     w_pick;
  logic                     w_clear;
  logic                     w_tick;
  logic                     w_byte_inc;
  logic                     w_timeout;
  logic                     w_bad_count;
  logic [SD_BYTE_CNT_W-1:0] w_byte_next;

  // A lone request wins regardless of the pointer; the pointer only breaks ties.
  assign w_pick      = (r0_req && r1_req) ? r_ptr : r1_req;
  assign w_bad_count = (w_byte_next != SD_BYTE_CNT_W'(SECTOR_BYTES));

  sd_xfer_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_counter (
    .clk               (clk),
    .rst               (rst),
    .i_clear           (w_clear),
    .i_byte            (w_byte_inc),
    .i_tick            (w_tick),
    .o_byte_count_next (w_byte_next),
    .o_timeout         (w_timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:       if (r0_req || r1_req) w_next_state = ST_WAIT_READY;
      ST_WAIT_READY: if (!sd_busy) w_next_state = ST_ISSUE;
      ST_ISSUE:      w_next_state = ST_TRANSFER;
      ST_TRANSFER:   if (sd_finished_sector || w_timeout) w_next_state = ST_RELEASE;
      ST_RELEASE:    w_next_state = ST_IDLE;
      default:       w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner           <= 1'b0;
      r_ptr             <= 1'b0;
      r_err             <= 1'b0;
      sd_op_code        <= SD_OP_READ;
      sd_sector_address <= '0;
    end else begin
      if ((r_state == ST_IDLE) && (r0_req || r1_req)) begin
        r_owner           <= w_pick;
        sd_op_code        <= w_pick ? r1_op : r0_op;
        sd_sector_address <= w_pick ? r1_sector : r0_sector;
      end
      // The same-cycle byte is already folded into w_byte_next before comparing.
      if ((r_state == ST_TRANSFER) && (sd_finished_sector || w_timeout)) begin
        r_err <= w_timeout || w_bad_count;
      end
      if (r_state == ST_RELEASE) begin
        r_ptr <= ~r_owner;
      end
    end
  end

  always_comb begin
    sd_execute       = (r_state == ST_ISSUE);
    w_clear          = (r_state == ST_ISSUE);
    w_tick           = (r_state == ST_TRANSFER);
    w_byte_inc       = w_tick && sd_finished_byte;
    r0_grant         = 1'b0;
    r1_grant         = 1'b0;
    r0_byte          = 1'b0;
    r1_byte          = 1'b0;
    r0_done          = 1'b0;
    r1_done          = 1'b0;
    r0_err           = 1'b0;
    r1_err           = 1'b0;
    sd_outgoing_byte = 8'h00;
    rdata            = w_tick ? sd_incoming_byte : 8'h00;
    if (r_state != ST_IDLE) begin
      r0_grant         = !r_owner;
      r1_grant         = r_owner;
      sd_outgoing_byte = r_owner ? r1_wdata : r0_wdata;
    end
    if (w_byte_inc) begin
      r0_byte = !r_owner;
      r1_byte = r_owner;
    end
    if (r_state == ST_RELEASE) begin
      r0_done = !r_owner;
      r1_done = r_owner;
      r0_err  = !r_owner && r_err;
      r1_err  = r_owner && r_err;
    end
  end

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Directed bench for sd_sector_arbiter: vector table of single transactions plus
// hand sequences for round-robin, mid-transfer reset and timeout abort.
module tb_sd_sector_arbiter;

  typedef struct {
    logic        q0;
    logic        q1;
    logic        op;
    logic [25:0] sector;
    logic [7:0]  wdata;
    int          nbytes;
    bit          same;
    int          busy;
    logic        exp_owner;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0_req = 1'b0, r0_op = 1'b0, r1_req = 1'b0, r1_op = 1'b0;
  logic [25:0] r0_sector = '0, r1_sector = '0;
  logic [7:0]  r0_wdata = '0, r1_wdata = '0;
  logic        r0_grant, r0_byte, r0_done, r0_err;
  logic        r1_grant, r1_byte, r1_done, r1_err;
  logic [7:0]  rdata;
  logic        sd_op_code, sd_execute;
  logic [25:0] sd_sector_address;
  logic [7:0]  sd_outgoing_byte;
  logic        sd_busy = 1'b0, sd_finished_byte = 1'b0, sd_finished_sector = 1'b0;
  logic [7:0]  sd_incoming_byte = '0;

  logic        t_req = 1'b0;
  logic        t_r0_grant, t_r0_byte, t_r0_done, t_r0_err;
  logic        t_r1_grant, t_r1_byte, t_r1_done, t_r1_err;
  logic [7:0]  t_rdata, t_outgoing;
  logic        t_op_code, t_execute;
  logic [25:0] t_address;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sd_sector_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_op(r0_op), .r0_sector(r0_sector), .r0_wdata(r0_wdata),
    .r0_grant(r0_grant), .r0_byte(r0_byte), .r0_done(r0_done), .r0_err(r0_err),
    .r1_req(r1_req), .r1_op(r1_op), .r1_sector(r1_sector), .r1_wdata(r1_wdata),
    .r1_grant(r1_grant), .r1_byte(r1_byte), .r1_done(r1_done), .r1_err(r1_err),
    .rdata(rdata),
    .sd_op_code(sd_op_code), .sd_sector_address(sd_sector_address),
    .sd_outgoing_byte(sd_outgoing_byte), .sd_execute(sd_execute),
    .sd_busy(sd_busy), .sd_finished_byte(sd_finished_byte),
    .sd_finished_sector(sd_finished_sector), .sd_incoming_byte(sd_incoming_byte)
  );

  // Short-timeout instance: never sees finished_sector, so it must abort on its own.
  sd_sector_arbiter #(.TIMEOUT_CYCLES(64)) dut_t (
    .clk(clk), .rst(rst),
    .r0_req(t_req), .r0_op(1'b1), .r0_sector(26'h55), .r0_wdata(8'h11),
    .r0_grant(t_r0_grant), .r0_byte(t_r0_byte), .r0_done(t_r0_done), .r0_err(t_r0_err),
    .r1_req(1'b0), .r1_op(1'b0), .r1_sector(26'h0), .r1_wdata(8'h00),
    .r1_grant(t_r1_grant), .r1_byte(t_r1_byte), .r1_done(t_r1_done), .r1_err(t_r1_err),
    .rdata(t_rdata),
    .sd_op_code(t_op_code), .sd_sector_address(t_address),
    .sd_outgoing_byte(t_outgoing), .sd_execute(t_execute),
    .sd_busy(1'b0), .sd_finished_byte(1'b0),
    .sd_finished_sector(1'b0), .sd_incoming_byte(8'h00)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered at a negedge with the DUT in IDLE; returns at the IDLE negedge after RELEASE.
  task automatic run_xfer(input vec_t v, input bit drop, input string tag);
    int          cyc;
    int          nb_own;
    int          nb_oth;
    int          rd_bad;
    int          execs;
    logic [1:0]  onehot;
    onehot = v.exp_owner ? 2'b10 : 2'b01;
    if (v.exp_owner == 1'b0) begin
      r0_op = v.op;  r0_sector = v.sector;  r0_wdata = v.wdata;
      r1_op = ~v.op; r1_sector = ~v.sector; r1_wdata = ~v.wdata;
    end else begin
      r1_op = v.op;  r1_sector = v.sector;  r1_wdata = v.wdata;
      r0_op = ~v.op; r0_sector = ~v.sector; r0_wdata = ~v.wdata;
    end
    r0_req  = v.q0;
    r1_req  = v.q1;
    sd_busy = (v.busy > 0);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == v.busy) sd_busy = 1'b0;
      #1;
    end while (!sd_execute && cyc < 200);
    check({tag, " exec latency"}, cyc, (v.busy > 1) ? v.busy + 1 : 2);
    check({tag, " grant"}, {r1_grant, r0_grant}, onehot);
    check({tag, " op_code"}, sd_op_code, v.op);
    check({tag, " sector"}, sd_sector_address, v.sector);
    check({tag, " outgoing"}, sd_outgoing_byte, v.wdata);

    nb_own = 0; nb_oth = 0; rd_bad = 0; execs = 0;
    for (int i = 0; i < v.nbytes; i++) begin
      @(negedge clk);
      sd_finished_byte   = 1'b1;
      sd_incoming_byte   = 8'(i * 7 + 3);
      sd_finished_sector = v.same && (i == v.nbytes - 1);
      #1;
      if (sd_execute) execs++;
      if (v.exp_owner ? r1_byte : r0_byte) nb_own++;
      if (v.exp_owner ? r0_byte : r1_byte) nb_oth++;
      if (v.exp_owner ? (r0_done | r1_done) : (r0_done | r1_done)) rd_bad++;
      if (rdata !== sd_incoming_byte) rd_bad++;
    end
    if (!v.same) begin
      @(negedge clk);
      sd_finished_byte   = 1'b0;
      sd_finished_sector = 1'b1;
      #1;
    end
    @(negedge clk);
    sd_finished_byte   = 1'b0;
    sd_finished_sector = 1'b0;
    #1;
    check({tag, " single exec"}, execs, 0);
    check({tag, " owner bytes"}, nb_own, v.nbytes);
    check({tag, " other bytes"}, nb_oth, 0);
    check({tag, " rdata/early done"}, rd_bad, 0);
    check({tag, " done"}, {r1_done, r0_done}, onehot);
    check({tag, " err"}, {r1_err, r0_err}, v.exp_err ? onehot : 2'b00);
    check({tag, " grant in release"}, {r1_grant, r0_grant}, onehot);
    if (drop) begin
      r0_req = 1'b0;
      r1_req = 1'b0;
    end
    @(negedge clk);
    #1;
    check({tag, " grant dropped"}, {r1_grant, r0_grant}, 2'b00);
    check({tag, " done cleared"}, {r1_done, r0_done}, 2'b00);
  endtask

  vec_t vecs[6];
  vec_t rr;

  initial begin
    int cyc;
    int done_seen;
    vecs[0] = '{1'b1, 1'b0, 1'b0, 26'h0000012, 8'hA5, 512, 1'b0, 0,  1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 26'h3ABCDEF, 8'h3C, 511, 1'b0, 0,  1'b1, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 26'h0000001, 8'h7E, 512, 1'b1, 0,  1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 26'h2000000, 8'h81, 513, 1'b0, 0,  1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 26'h1555555, 8'h00, 512, 1'b0, 20, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 26'h0AAAAAA, 8'hFF, 511, 1'b1, 1,  1'b1, 1'b1};

    // Requests held during reset must not produce a grant.
    r0_req = 1'b1; r1_req = 1'b1; t_req = 1'b1;
    r0_wdata = 8'h5A; r1_wdata = 8'hC3; r0_sector = 26'h123; r0_op = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset grants", {r1_grant, r0_grant, t_r0_grant}, 3'b000);
    check("reset pulses", {r0_byte, r1_byte, r0_done, r1_done, r0_err, r1_err}, 6'b0);
    check("reset sd ctrl", {sd_execute, sd_op_code, t_execute}, 3'b000);
    check("reset sd addr", sd_sector_address, 26'h0);
    check("reset outgoing", sd_outgoing_byte, 8'h00);
    @(negedge clk);
    rst = 1'b0; t_req = 1'b0;

    // Both requesting from reset: pointer starts at r0, then alternates.
    for (int k = 0; k < 4; k++) begin
      rr = '{1'b1, 1'b1, k[0], 26'(32'h100 + k), 8'(8'h40 + k), 512, 1'b0, 0, k[0], 1'b0};
      run_xfer(rr, k == 3, $sformatf("rr%0d", k));
    end

    foreach (vecs[i]) run_xfer(vecs[i], 1'b1, $sformatf("vec%0d", i));

    // Reset in the middle of a transfer, after 100 bytes.
    r0_req = 1'b1; r0_op = 1'b1; r0_sector = 26'h0ABCDE; r0_wdata = 8'h99;
    cyc = 0;
    do begin @(negedge clk); cyc++; #1; end while (!sd_execute && cyc < 50);
    check("mid-rst exec latency", cyc, 2);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      sd_finished_byte = 1'b1;
    end
    @(negedge clk);
    sd_finished_byte = 1'b0;
    #1;
    check("mid-rst grant before", r0_grant, 1'b1);
    rst = 1'b1;
    #1;
    check("mid-rst outputs", {r0_grant, r1_grant, r0_byte, r0_done, r0_err, sd_execute, sd_op_code}, 7'b0);
    check("mid-rst address", sd_sector_address, 26'h0);
    check("mid-rst outgoing", sd_outgoing_byte, 8'h00);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (r0_done || r1_done) done_seen++;
    end
    rst = 1'b0; r0_req = 1'b0;
    repeat (2) begin
      @(negedge clk); #1;
      if (r0_done || r1_done || r0_grant) done_seen++;
    end
    check("mid-rst no done", done_seen, 0);
    run_xfer(vecs[0], 1'b1, "post-rst");

    // Timeout: ISSUE, then 64 TRANSFER cycles (counter 0..63), then RELEASE.
    t_req = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; #1; end while (!t_execute && cyc < 50);
    check("timeout exec latency", cyc, 2);
    cyc = 0;
    do begin @(negedge clk); cyc++; #1; end while (!t_r0_done && cyc < 200);
    check("timeout done cycle", cyc, 65);
    check("timeout err", t_r0_err, 1'b1);
    check("timeout grant in release", t_r0_grant, 1'b1);
    t_req = 1'b0;
    @(negedge clk); #1;
    check("timeout grant dropped", {t_r0_grant, t_r0_done}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/sd_sector_arbiter.md
SD_SECTOR_ARBITER -- requirements
Module: sd_sector_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1048576, sets the cycles allowed from execute to finished_sector before abort.
REQ-002 Parameter SECTOR_BYTES, default 512, sets the expected finished_byte pulses per sector.
REQ-003 Clocking SHALL be one clock, clk, with reset rst, asynchronous and active-high.
REQ-004 clk  input  1  master clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 rN_req  input  1  requester N (N=0,1) wants one sector op; held until rN_done.
REQ-007 rN_op  input  1  0=READ, 1=WRITE; sampled at grant.
REQ-008 rN_sector  input  26  sector address; sampled at grant.
REQ-009 rN_wdata  input  8  write byte, forwarded combinationally while rN granted.
REQ-010 rN_grant  output  1  high for the whole owned transaction.
REQ-011 rN_byte  output  1  one-cycle pulse per byte moved for requester N.
REQ-012 rN_done  output  1  one-cycle pulse at transaction end.
REQ-013 rN_err  output  1  qualifies rN_done: timeout or byte-count mismatch.
REQ-014 rdata  output  8  sd_incoming_byte passthrough, valid with rN_byte on reads.
REQ-015 sd_op_code, sd_sector_address (26), sd_outgoing_byte (8), sd_execute  outputs to SD controller.
REQ-016 sd_busy, sd_finished_byte, sd_finished_sector, sd_incoming_byte (8)  inputs from SD controller.

Function
REQ-017 FSM states: IDLE, WAIT_READY, ISSUE, TRANSFER, RELEASE.
REQ-018 IDLE: if any rN_req, grant per round-robin pointer; latch op/sector into sd_op_code/sd_sector_address; go WAIT_READY.
REQ-019 Round-robin: pointer names preferred requester; on simultaneous requests the preferred wins; pointer moves to the other requester in RELEASE.
REQ-020 Single request SHALL be granted regardless of pointer, without an idle cycle.
REQ-021 WAIT_READY: stay while sd_busy high; when low go ISSUE.
REQ-022 ISSUE: sd_execute high exactly one cycle; clear byte counter and timeout counter; go TRANSFER.
REQ-023 TRANSFER: each sd_finished_byte increments the byte counter and pulses rN_byte the same cycle.
REQ-024 TRANSFER exits on sd_finished_sector; rN_err = (byte count incl. same-cycle byte != SECTOR_BYTES).
REQ-025 sd_finished_byte and sd_finished_sector in the same cycle: byte SHALL be counted before comparison.
REQ-026 Timeout counter reaching TIMEOUT_CYCLES-1 in TRANSFER forces RELEASE with rN_err=1.
REQ-027 RELEASE: pulse rN_done (+rN_err), drop rN_grant next cycle, advance pointer, return IDLE.
REQ-028 Requester dropping rN_req mid-transaction SHALL NOT abort; transaction completes and done still pulses.
REQ-029 Latency req-to-sd_execute with sd_busy low: 3 cycles (IDLE, WAIT_READY, ISSUE).
REQ-030 Ungranted requester's outputs rN_byte, rN_done, rN_err SHALL stay 0.
REQ-031 sd_outgoing_byte = granted rN_wdata; 8'h00 when no grant.
REQ-032 Byte counter 10 bits, saturating at 1023; timeout counter width $clog2(TIMEOUT_CYCLES).

Reset
REQ-033 rst SHALL force IDLE, pointer=0, counters=0, all outputs 0 including sd_execute and grants.
REQ-034 rst mid-transaction: no rN_done emitted; SD controller is not signalled beyond sd_execute=0.

Structure
REQ-035 State encodings and SECTOR_BYTES default SHALL reside in shared package sd_pkg alongside SD command constants.
REQ-036 Counter pair (byte + timeout) SHALL be sub-module sd_xfer_counter; arbitration and FSM stay top-level.

Verification
REQ-037 r0_req only, op=0, sector=26'h12, sd_busy=0, 512 byte pulses then finished_sector -> sd_execute at cycle 3, 512 r0_byte, r0_done=1, r0_err=0.
REQ-038 r0_req and r1_req same cycle after reset -> r0 served first, then r1 without intermediate idle request gap; pointer alternates over 4 transactions.
REQ-039 finished_sector after 511 bytes -> r1_done=1 with r1_err=1.
REQ-040 TIMEOUT_CYCLES=64, no finished_sector -> done+err 64 cycles after ISSUE, grant released.
REQ-041 sd_busy held high 20 cycles after grant -> sd_execute delayed until busy low; exactly one pulse.
REQ-042 rst asserted at byte 100 -> all outputs 0 immediately, no done pulse, next request served normally.
